hazard_ctrl: RTL

//  Pipeline sequencing controller for the 5-stage RISC-V core, beside the EX-stage forwarding unit.

---
 rtl/hazard_if.sv | 57 +++++
 rtl/hazard_ctrl.sv | 132 +++++++++++++
 2 files changed

// File: rtl/hazard_if.sv
// Handshake bundle between the ID/EX hazard sources and the sequencing controller.
// Inputs describe the ID and EX instructions; outputs steer pipeline registers.
interface hazard_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       ID_Rs1_i;
    logic [4:0]       ID_Rs2_i;
    logic             ID_UsesRs2_i;
    logic             EX_MemRead_i;
    logic [4:0]       EX_Rd_i;
    logic             EX_MulDiv_i;
    logic             ID_Flush_i;
    logic             PC_Write_o;
    logic             IFID_Write_o;
    logic             IFID_Flush_o;
    logic             IDEX_Write_o;
    logic             IDEX_Bubble_o;
    logic             EXMEM_Bubble_o;
    logic             MD_Done_o;
    logic [CNT_W-1:0] Stall_Cnt_o;

    modport master (
        output ID_Rs1_i,
        output ID_Rs2_i,
        output ID_UsesRs2_i,
        output EX_MemRead_i,
        output EX_Rd_i,
        output EX_MulDiv_i,
        output ID_Flush_i,
        input  PC_Write_o,
        input  IFID_Write_o,
        input  IFID_Flush_o,
        input  IDEX_Write_o,
        input  IDEX_Bubble_o,
        input  EXMEM_Bubble_o,
        input  MD_Done_o,
        input  Stall_Cnt_o
    );

    modport slave (
        input  ID_Rs1_i,
        input  ID_Rs2_i,
        input  ID_UsesRs2_i,
        input  EX_MemRead_i,
        input  EX_Rd_i,
        input  EX_MulDiv_i,
        input  ID_Flush_i,
        output PC_Write_o,
        output IFID_Write_o,
        output IFID_Flush_o,
        output IDEX_Write_o,
        output IDEX_Bubble_o,
        output EXMEM_Bubble_o,
        output MD_Done_o,
        output Stall_Cnt_o
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, MUL/DIV EX occupancy,
// flush gating and a saturating stall-cycle counter.
module hazard_ctrl #(
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic    clk_i,
    input  logic    rst_i,
    hazard_if.slave hz
);
    localparam int CW = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'((MD_LAT > 1) ? MD_LAT - 2 : 0);

    typedef enum logic {
        RUN = 1'b0,
        MD  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic md_stall;
    logic lu_stall;
    logic md_done;
    logic rd_hit;
    logic pc_we;
    logic ifid_we;
    logic ifid_fl;
    logic idex_we;
    logic idex_bub;
    logic exmem_bub;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RUN;
            cnt_q   <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pc_we     = 1'b1;
        ifid_we   = 1'b1;
        idex_we   = 1'b1;
        idex_bub  = 1'b0;
        exmem_bub = 1'b0;

        md_stall = ((state_q == RUN) && hz.EX_MulDiv_i && (MD_LAT > 1))
                || ((state_q == MD) && (cnt_q != '0));

        rd_hit = (hz.EX_Rd_i != 5'd0)
              && ((hz.EX_Rd_i == hz.ID_Rs1_i)
              || (hz.ID_UsesRs2_i && (hz.EX_Rd_i == hz.ID_Rs2_i)));

        lu_stall = (state_q == RUN) && !md_stall
                && hz.EX_MemRead_i && rd_hit;

        md_done = ((state_q == MD) && (cnt_q == '0))
               || ((state_q == RUN) && hz.EX_MulDiv_i && (MD_LAT == 1));

        // EX_MulDiv_i is ignored in MD so the held op cannot retrigger.
        unique case (state_q)
            RUN: begin
                if (md_stall) begin
                    state_d = MD;
                    cnt_d   = CNT_INIT;
                end
            end
            MD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase

        unique case (1'b1)
            md_stall: begin
                pc_we     = 1'b0;
                ifid_we   = 1'b0;
                idex_we   = 1'b0;
                exmem_bub = 1'b1;
            end
            lu_stall: begin
                pc_we    = 1'b0;
                ifid_we  = 1'b0;
                idex_bub = 1'b1;
            end
            default: begin
                pc_we = 1'b1;
            end
        endcase

        ifid_fl = hz.ID_Flush_i && !md_stall && !lu_stall;

        if (rst_i) begin
            pc_we     = 1'b1;
            ifid_we   = 1'b1;
            idex_we   = 1'b1;
            idex_bub  = 1'b0;
            exmem_bub = 1'b0;
            ifid_fl   = 1'b0;
            md_done   = 1'b0;
        end

        stall_d = stall_q;
        if (!pc_we && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    assign hz.PC_Write_o     = pc_we;
    assign hz.IFID_Write_o   = ifid_we;
    assign hz.IFID_Flush_o   = ifid_fl;
    assign hz.IDEX_Write_o   = idex_we;
    assign hz.IDEX_Bubble_o  = idex_bub;
    assign hz.EXMEM_Bubble_o = exmem_bub;
    assign hz.MD_Done_o      = md_done;
    assign hz.Stall_Cnt_o    = stall_q;
endmodule
